array_accu_ctrl: RTL and testbench

ARRAY_ACCU_CTRL -- requirements
Module: array_accu_ctrl

---
 rtl/accu_pkg.sv | 22 ++
 rtl/array_accu_pl.sv | 52 +++++
 rtl/array_accu_ctrl.sv | 120 ++++++++++++
 tb/tb_array_accu_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// Shared definitions for the array accumulator controller.
//   state_t    : controller FSM encoding
//   DATA_SIZE  : lane count for the default cache-line / lane widths
//   lane_count : lane count for any parameterisation
package accu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCU  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_CACHE_WIDTH = 512;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DATA_SIZE       = DEF_CACHE_WIDTH / DEF_DATA_WIDTH;

  function automatic int lane_count(input int cache_w, input int data_w);
    return cache_w / data_w;
  endfunction

endpackage

// File: rtl/array_accu_pl.sv
// Lane-wise accumulator datapath.
//   clk, rst : clock, synchronous active-high clear of all lanes
//   inc      : add data into the running sums
//   out      : add data and emit the total into result; sums restart at 0
//   data     : input cache line (NUM_LANES x DATA_WIDTH)
//   ready    : result valid, one cycle after out
//   result   : lane-wise totals
module array_accu_pl
  import accu_pkg::*;
#(
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   out,
  input  logic [CACHE_WIDTH-1:0] data,
  output logic                   ready,
  output logic [CACHE_WIDTH-1:0] result
);

  localparam int NUM_LANES = lane_count(CACHE_WIDTH, DATA_WIDTH);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] din;
  assign din = data;

  always_ff @(posedge clk) begin
    if (rst) ready <= 1'b0;
    else     ready <= out;
  end

  // Each lane wraps independently; no carry crosses a lane boundary.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] acc, res;

    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
        res <= '0;
      end else if (inc) begin
        acc <= acc + din[l];
      end else if (out) begin
        res <= acc + din[l];
        acc <= '0;
      end
    end

    assign result[l*DATA_WIDTH +: DATA_WIDTH] = res;
  end

endmodule

// File: rtl/array_accu_ctrl.sv
// Job controller for lane-wise reduction of cache lines.
// A job is cfg_blocks reductions of cfg_len lines each; every reduction
// produces one res_data line held until res_ready.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : job start pulse (IDLE only), job cancel
//   cfg_len, cfg_blocks : lines per reduction, reductions per job
//   in_valid/in_ready/in_data    : input line handshake
//   res_valid/res_ready/res_data : result handshake
//   busy : not IDLE;  err : pulse on start with a zero config
module array_accu_ctrl
  import accu_pkg::*;
#(
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   cfg_len,
  input  logic [CNT_WIDTH-1:0]   cfg_blocks,
  input  logic                   in_valid,
  input  logic [CACHE_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   res_valid,
  output logic [CACHE_WIDTH-1:0] res_data,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   err
);

  state_t state, state_nx;

  logic [CNT_WIDTH-1:0]   len_q, lines_left, blocks_left;
  logic                   acc_inc, acc_out, acc_clr, acc_rdy;
  logic [CACHE_WIDTH-1:0] acc_res;

  logic cfg_ok, start_ok, in_fire, res_fire, last_line, more_blocks;

  assign cfg_ok      = (cfg_len != '0) && (cfg_blocks != '0);
  // abort outranks start even while idle
  assign start_ok    = (state == IDLE) && start && !abort && cfg_ok;
  assign in_fire     = in_valid && in_ready;
  assign res_fire    = res_valid && res_ready;
  assign last_line   = (lines_left == CNT_WIDTH'(1));
  assign more_blocks = (blocks_left > CNT_WIDTH'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nx = ACCU;
        ACCU:    if (in_fire && last_line) state_nx = DRAIN;
        DRAIN:   if (acc_rdy) state_nx = HOLD;
        HOLD:    if (res_fire) state_nx = more_blocks ? ACCU : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    in_ready  = (state == ACCU);
    res_valid = (state == HOLD);
    busy      = (state != IDLE);
    err       = (state == IDLE) && start && !abort && !cfg_ok;
    acc_clr   = start_ok || (abort && state != IDLE);
    acc_inc   = (state == ACCU) && in_fire && !last_line && !abort;
    acc_out   = (state == ACCU) && in_fire &&  last_line && !abort;
  end

  // counters and result register
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      len_q       <= '0;
      lines_left  <= '0;
      blocks_left <= '0;
      res_data    <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          len_q       <= cfg_len;
          lines_left  <= cfg_len;
          blocks_left <= cfg_blocks;
        end
        ACCU:  if (in_fire) lines_left <= lines_left - CNT_WIDTH'(1);
        DRAIN: if (acc_rdy) res_data <= acc_res;
        HOLD: if (res_fire && more_blocks) begin
          blocks_left <= blocks_left - CNT_WIDTH'(1);
          lines_left  <= len_q;
        end
        default: ;
      endcase
    end
  end

  array_accu_pl #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_pl (
    .clk    (clk),
    .rst    (rst || acc_clr),
    .inc    (acc_inc),
    .out    (acc_out),
    .data   (in_data),
    .ready  (acc_rdy),
    .result (acc_res)
  );

endmodule

// File: tb/tb_array_accu_ctrl.sv
module tb_array_accu_ctrl;

  localparam int CW = 512;
  localparam int DW = 32;
  localparam int CN = 16;
  localparam int NL = CW / DW;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid, res_ready;
  logic [CN-1:0] cfg_len, cfg_blocks;
  logic [CW-1:0] in_data, res_data;
  logic          in_ready, res_valid, busy, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [CW-1:0] exp_q[$];

  array_accu_ctrl #(.CACHE_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(CN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_blocks(cfg_blocks),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] fill(input logic [DW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every result handshake pops one expectation
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got %h want none", res_data);
      end else begin
        chk("sb_result", res_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int len, input int blocks, output logic err_seen);
    start = 1'b1; cfg_len = CN'(len); cfg_blocks = CN'(blocks);
    @(negedge clk); err_seen = err;
    tick();
    start = 1'b0;
  endtask

  // offer one line until taken; on the final line also check T+1 / T+2 timing
  task automatic send_line(input logic [CW-1:0] d, input bit last);
    logic ok;
    int n = 0;
    in_valid = 1'b1; in_data = d;
    forever begin
      @(negedge clk); ok = in_ready;
      tick();
      if (ok) break;
      if (++n > 60) begin
        total++; bad++;
        $display("FAIL send_timeout: got no in_ready want in_ready");
        break;
      end
    end
    in_valid = 1'b0;
    if (last) begin
      @(negedge clk); chk("lat_T1_low", CW'(res_valid), CW'(0));
      tick();
      @(negedge clk); chk("lat_T2_high", CW'(res_valid), CW'(1));
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin tick(); n++; end
    @(negedge clk); chk(name, CW'(busy), CW'(0));
    tick();
  endtask

  initial begin
    logic          e;
    logic [CW-1:0] a, b, ex;

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    cfg_len = '0; cfg_blocks = '0; in_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", CW'(in_ready), CW'(0));
    chk("rst_res_valid", CW'(res_valid), CW'(0));
    chk("rst_res_data", res_data, CW'(0));
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_err", CW'(err), CW'(0));
    rst = 1'b0;
    tick();

    // 1+2+3+4 = 10 in every lane
    exp_q.push_back(fill(10));
    do_start(4, 1, e);
    chk("start_no_err", CW'(e), CW'(0));
    for (int i = 1; i <= 4; i++) send_line(fill(DW'(i)), i == 4);
    wait_idle("idle_after_single");

    // three blocks of two lines: 5+6, 1+1, 0+9
    exp_q.push_back(fill(11)); exp_q.push_back(fill(2)); exp_q.push_back(fill(9));
    do_start(2, 3, e);
    send_line(fill(5), 0); send_line(fill(6), 1);
    send_line(fill(1), 0); send_line(fill(1), 1);
    send_line(fill(0), 0); send_line(fill(9), 1);
    wait_idle("idle_after_multi");

    // backpressure in HOLD: output stable, offered line not taken
    res_ready = 1'b0;
    exp_q.push_back(fill(3));
    do_start(1, 1, e);
    send_line(fill(3), 1);
    in_valid = 1'b1; in_data = fill(99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", CW'(in_ready), CW'(0));
      chk("hold_data", res_data, fill(3));
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("idle_after_hold");
    exp_q.push_back(fill(4));
    do_start(1, 1, e);
    send_line(fill(4), 1);
    wait_idle("idle_after_hold_next");

    // lane 0 wraps, other lanes untouched by it
    a = fill(5); a[DW-1:0] = 32'hFFFF_FFFF;
    b = fill(7); b[DW-1:0] = 32'h2;
    ex = fill(12); ex[DW-1:0] = 32'h1;
    exp_q.push_back(ex);
    do_start(2, 1, e);
    send_line(a, 0); send_line(b, 1);
    wait_idle("idle_after_wrap");

    // abort mid-reduction, restart from a clean sum
    do_start(4, 1, e);
    send_line(fill(8), 0); send_line(fill(8), 0);
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_busy", CW'(busy), CW'(0));
    chk("abort_res_valid", CW'(res_valid), CW'(0));
    tick();
    exp_q.push_back(fill(7));
    do_start(1, 1, e);
    send_line(fill(7), 1);
    wait_idle("idle_after_abort");

    // cfg_len=1: each line is its own result
    exp_q.push_back(fill(3)); exp_q.push_back(fill(40));
    do_start(1, 2, e);
    send_line(fill(3), 1); send_line(fill(40), 1);
    wait_idle("idle_after_len1");

    // rejected starts
    do_start(0, 3, e);
    chk("err_len0", CW'(e), CW'(1));
    @(negedge clk);
    chk("err_len0_busy", CW'(busy), CW'(0));
    chk("err_len0_pulse", CW'(err), CW'(0));
    tick();
    do_start(3, 0, e);
    chk("err_blk0", CW'(e), CW'(1));

    // reset mid-ACCU, then a fresh job
    do_start(3, 1, e);
    send_line(fill(6), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", CW'(in_ready), CW'(0));
    chk("mid_rst_busy", CW'(busy), CW'(0));
    chk("mid_rst_res_data", res_data, CW'(0));
    chk("mid_rst_res_valid", CW'(res_valid), CW'(0));
    tick();
    exp_q.push_back(fill(5));
    do_start(1, 1, e);
    send_line(fill(5), 1);
    wait_idle("idle_after_rst");

    repeat (3) tick();
    chk("sb_drained", CW'(exp_q.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
